sram_mem_ctrl: RTL

- Sits directly downstream of the SLC-3 control FSM, between the Mem_OE/Mem_WE strobes plus the MAR/MDR datapath registers and the external asynchronous 16-bit SRAM.
- Sequences SRAM chip-enable, output-enable and write-enable strobes with configurable wait states. Returns read data and a Mem_Ready completion pulse, so the control FSM can wait on a handshake instead of fixed wait states.
- Decodes one memory-mapped I/O address: reads there return the switch inputs; writes there load the hex-display register.

---
 rtl/sram_mem_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sram_mem_ctrl.sv
// SLC-3 memory controller: strobes an async 16-bit SRAM and decodes one memory-mapped I/O register.
// Read Ready at RD_WAIT_CYCLES+1, write Ready at WR_PULSE_CYCLES+3, I/O Ready at 1; no backpressure, requests are level-held.
module sram_mem_ctrl #(
    parameter int          RD_WAIT_CYCLES  = 2,
    parameter int          WR_PULSE_CYCLES = 1,
    parameter logic [15:0] IO_ADDR         = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR_out,
    input  logic [15:0] Switches,
    output logic [15:0] Data_to_CPU,
    output logic        Mem_Ready,
    output logic [15:0] Hex_Reg,
    output logic [19:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam int CNT_MAX = (RD_WAIT_CYCLES > WR_PULSE_CYCLES) ? RD_WAIT_CYCLES : WR_PULSE_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] RD_LAST = CW'(RD_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] WR_LAST = CW'(WR_PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [15:0]   wr_dat;
    logic          dq_drv;
    logic          req;
    logic          io_hit;
    logic          ce_nxt;
    logic          oe_nxt;
    logic          we_nxt;
    logic          drv_nxt;
    logic          rdy_nxt;

    assign req     = Mem_OE | Mem_WE;
    assign io_hit  = (MAR == IO_ADDR);
    assign SRAM_DQ = dq_drv ? wr_dat : 16'hzzzz;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (io_hit)      state_nxt = DONE;
                    else if (Mem_WE) state_nxt = WR_SETUP;
                    else             state_nxt = RD;
                end
            end
            RD:       if (cnt == RD_LAST) state_nxt = DONE;
            WR_SETUP: state_nxt = WR_PULSE;
            WR_PULSE: if (cnt == WR_LAST) state_nxt = WR_HOLD;
            WR_HOLD:  state_nxt = DONE;
            DONE:     if (!req) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase

        // Strobes are registered, so they are derived from the state being entered.
        ce_nxt  = state_nxt inside {RD, WR_SETUP, WR_PULSE, WR_HOLD};
        oe_nxt  = (state_nxt == RD);
        we_nxt  = (state_nxt == WR_PULSE);
        drv_nxt = state_nxt inside {WR_SETUP, WR_PULSE, WR_HOLD};
        rdy_nxt = (state_nxt == DONE) && (state != DONE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            wr_dat      <= '0;
            dq_drv      <= 1'b0;
            SRAM_ADDR   <= '0;
            SRAM_CE_N   <= 1'b1;
            SRAM_OE_N   <= 1'b1;
            SRAM_WE_N   <= 1'b1;
            SRAM_UB_N   <= 1'b1;
            SRAM_LB_N   <= 1'b1;
            Data_to_CPU <= '0;
            Hex_Reg     <= '0;
            Mem_Ready   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= (state_nxt != state) ? '0 : cnt + CW'(1);
            dq_drv    <= drv_nxt;
            SRAM_CE_N <= !ce_nxt;
            SRAM_UB_N <= !ce_nxt;
            SRAM_LB_N <= !ce_nxt;
            SRAM_OE_N <= !oe_nxt;
            SRAM_WE_N <= !we_nxt;
            Mem_Ready <= rdy_nxt;

            if (state == IDLE && req) begin
                SRAM_ADDR <= {4'b0, MAR};
                wr_dat    <= MDR_out;
                if (io_hit) begin
                    if (Mem_WE) Hex_Reg     <= MDR_out;
                    else        Data_to_CPU <= Switches;
                end
            end

            if (state == RD && state_nxt == DONE)
                Data_to_CPU <= SRAM_DQ;
        end
    end

endmodule
